// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if: shared-bus request/response and grant signals between masters, slave and arbiter.
interface wb_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int N_BITS_ID = $clog2(N_MASTERS)
);
  logic [N_MASTERS-1:0] cyc_i;
  logic [N_MASTERS-1:0] stb_i;
  logic                 ack_i;
  logic                 err_i;
  logic                 rty_i;
  logic [N_MASTERS-1:0] gnt_o;
  logic [N_BITS_ID-1:0] gnt_id_o;
  logic                 bus_busy_o;
  logic [N_MASTERS-1:0] timeout_err_o;
  modport arb (
    input  cyc_i, stb_i, ack_i, err_i, rty_i,
    output gnt_o, gnt_id_o, bus_busy_o, timeout_err_o
  );
  modport master (
    output cyc_i, stb_i, ack_i, err_i, rty_i,
    input  gnt_o, gnt_id_o, bus_busy_o, timeout_err_o
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin Wishbone arbiter holding grants per CYC, with a response watchdog.
module wb_bus_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int N_BITS_ID      = $clog2(N_MASTERS),
  parameter int TIMEOUT_CYCLES = 255,
  parameter int N_BITS_TIMEOUT = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic            clk,
  input logic            rst,
  wb_bus_arbiter_if.arb  bus
);
  localparam int CW = (N_BITS_TIMEOUT < 1) ? 1 : N_BITS_TIMEOUT;
  typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} state_t;
  state_t               r_state, w_next_state;
  logic [N_MASTERS-1:0] r_gnt, w_gnt;
  logic [N_BITS_ID-1:0] r_gnt_id, w_gnt_id;
  logic [N_BITS_ID-1:0] r_last, w_last;
  logic [N_MASTERS-1:0] r_terr, w_terr;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic                 w_found;
  logic [N_BITS_ID-1:0] w_win;
  logic                 w_owner_cyc, w_arb, w_wait, w_expire;
  // Search begins just past the previous owner so every requester gets a turn.
  always_comb begin
    logic [N_BITS_ID-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = N_BITS_ID'((int'(r_last) + k) % N_MASTERS);
      if (!w_found && bus.cyc_i[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end
  assign w_owner_cyc = bus.cyc_i[r_gnt_id];
  assign w_arb       = (r_state == IDLE) || !w_owner_cyc;
  assign w_wait      = (r_state == GRANTED) && w_owner_cyc && bus.stb_i[r_gnt_id] &&
                       !(bus.ack_i || bus.err_i || bus.rty_i);
  assign w_expire    = (TIMEOUT_CYCLES > 0) && w_wait && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_next_state = w_arb ? (w_found ? GRANTED : IDLE) : (w_expire ? DRAIN : r_state);
    w_gnt        = w_arb ? (w_found ? N_MASTERS'(1) << w_win : '0) : r_gnt;
    w_gnt_id     = (w_arb && w_found) ? w_win : r_gnt_id;
    w_last       = (w_arb && w_found) ? w_win : r_last;
    w_terr       = w_expire ? r_gnt : '0;
    w_cnt        = (!w_arb && w_wait && !w_expire && TIMEOUT_CYCLES > 0) ? r_cnt + CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_last   <= N_BITS_ID'(N_MASTERS - 1);
      r_terr   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next_state;
      r_gnt    <= w_gnt;
      r_gnt_id <= w_gnt_id;
      r_last   <= w_last;
      r_terr   <= w_terr;
      r_cnt    <= w_cnt;
    end
  end
  assign bus.gnt_o         = r_gnt;
  assign bus.gnt_id_o      = r_gnt_id;
  assign bus.bus_busy_o    = |r_gnt;
  assign bus.timeout_err_o = r_terr;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed checks of grant sequencing, round-robin handoff and the watchdog.
module tb_wb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wb_bus_arbiter_if #(.N_MASTERS(2)) bus ();
  wb_bus_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic a);
    bus.cyc_i = c;
    bus.stb_i = s;
    bus.ack_i = a;
    bus.err_i = 1'b0;
    bus.rty_i = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic [1:0] g, input logic id,
                            input logic busy, input logic [1:0] te);
    chk({tag, ".gnt"}, 8'(bus.gnt_o), 8'(g));
    if (busy) chk({tag, ".id"}, 8'(bus.gnt_id_o), 8'(id));
    chk({tag, ".busy"}, 8'(bus.bus_busy_o), 8'(busy));
    chk({tag, ".terr"}, 8'(bus.timeout_err_o), 8'(te));
  endtask
  initial begin
    drive(2'b00, 2'b00, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.cyc_i = 2'($urandom);
      bus.stb_i = 2'($urandom);
      bus.ack_i = 1'($urandom);
      bus.err_i = 1'($urandom);
      bus.rty_i = 1'($urandom);
      step();
      expect_out("reset", 2'b00, 1'b0, 1'b0, 2'b00);
      chk("reset.id0", 8'(bus.gnt_id_o), 8'd0);
    end
    rst = 1'b0;
    drive(2'b00, 2'b00, 1'b0);
    step();
    expect_out("idle", 2'b00, 1'b0, 1'b0, 2'b00);
    // single request from master 1
    drive(2'b10, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("single", 2'b10, 1'b1, 1'b1, 2'b00);
    end
    drive(2'b00, 2'b00, 1'b0);
    step();
    expect_out("single_rel", 2'b00, 1'b0, 1'b0, 2'b00);
    // round robin after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(2'b11, 2'b00, 1'b0);
    step();
    expect_out("rr_first", 2'b01, 1'b0, 1'b1, 2'b00);
    step();
    expect_out("rr_hold0", 2'b01, 1'b0, 1'b1, 2'b00);
    drive(2'b10, 2'b00, 1'b0);
    step();
    expect_out("rr_hand1", 2'b10, 1'b1, 1'b1, 2'b00);
    drive(2'b11, 2'b00, 1'b0);
    step();
    expect_out("rr_nopreempt", 2'b10, 1'b1, 1'b1, 2'b00);
    drive(2'b01, 2'b00, 1'b0);
    step();
    expect_out("rr_hand0", 2'b01, 1'b0, 1'b1, 2'b00);
    drive(2'b10, 2'b00, 1'b0);
    step();
    expect_out("rr_hand1b", 2'b10, 1'b1, 1'b1, 2'b00);
    drive(2'b01, 2'b00, 1'b0);
    step();
    expect_out("rr_hand0b", 2'b01, 1'b0, 1'b1, 2'b00);
    drive(2'b00, 2'b00, 1'b0);
    step();
    expect_out("rr_idle", 2'b00, 1'b0, 1'b0, 2'b00);
    // watchdog: last owner 0, master 0 alone requests and is never answered
    drive(2'b01, 2'b01, 1'b0);
    step();
    expect_out("wd_gnt", 2'b01, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("wd_wait", 2'b01, 1'b0, 1'b1, 2'b00);
    end
    step();
    expect_out("wd_pulse", 2'b01, 1'b0, 1'b1, 2'b01);
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("wd_drain", 2'b01, 1'b0, 1'b1, 2'b00);
    end
    drive(2'b10, 2'b00, 1'b0);
    step();
    expect_out("wd_hand1", 2'b10, 1'b1, 1'b1, 2'b00);
    drive(2'b00, 2'b00, 1'b0);
    step();
    expect_out("wd_idle", 2'b00, 1'b0, 1'b0, 2'b00);
    // race: ack on the expiring cycle wins and restarts the count
    drive(2'b01, 2'b01, 1'b0);
    step();
    expect_out("race_gnt", 2'b01, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("race_wait", 2'b01, 1'b0, 1'b1, 2'b00);
    end
    bus.ack_i = 1'b1;
    step();
    expect_out("race_ack", 2'b01, 1'b0, 1'b1, 2'b00);
    bus.ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("race_rewait", 2'b01, 1'b0, 1'b1, 2'b00);
    end
    step();
    expect_out("race_pulse", 2'b01, 1'b0, 1'b1, 2'b01);
    drive(2'b00, 2'b00, 1'b0);
    step();
    expect_out("race_rel", 2'b00, 1'b0, 1'b0, 2'b00);
    // reset while master 0 owns the bus with the counter at 2
    drive(2'b01, 2'b01, 1'b0);
    step();
    expect_out("mid_gnt", 2'b01, 1'b0, 1'b1, 2'b00);
    step();
    step();
    expect_out("mid_cnt2", 2'b01, 1'b0, 1'b1, 2'b00);
    rst = 1'b1;
    step();
    expect_out("mid_rst", 2'b00, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;
    drive(2'b11, 2'b00, 1'b0);
    step();
    expect_out("mid_win0", 2'b01, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("mid_nopulse", 2'b01, 1'b0, 1'b1, 2'b00);
    end
    drive(2'b00, 2'b00, 1'b0);
    step();
    expect_out("end_idle", 2'b00, 1'b0, 1'b0, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
